dec_stage_pipe: RTL

- Parametrised, pipelined successor to the single-cycle combinational instruction decoder.
- Splits the instruction into fields and generates datapath control.
- Registers the full decoded bundle into a decode→execute pipeline register with valid/ready handshake.
- Adds a load-use interlock and a flush. Sits between fetch and execute/register-file/memory control.

---
 rtl/dec_stage_pipe_if.sv | 49 ++++
 rtl/dec_stage_pipe.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/dec_stage_pipe_if.sv
// Decode-stage bus: fetch-side request, execute-side decoded bundle, interlock status.
// Optional DEC_ILLEGAL_TRAP_EN adds illegal_d / illegal_seen.
interface dec_stage_pipe_if #(
  parameter int REG_W  = 3,
  parameter int OSEL_W = 4
);
  localparam int INSTR_W = 4 + 4*REG_W;

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instruction;
  logic               neg;
  logic               zer;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         opcode_d;
  logic [REG_W-1:0]   rs_d, rt_d, rd_d, shamt_d, funct_d;
  logic [2*REG_W-1:0] constant_d;
  logic [3*REG_W-1:0] address_d;
  logic               const_en_d, write_en_d, read_en_d, write_en2_d;
  logic               j_sel_d, pc_sel_d, hilo_en_d;
  logic [OSEL_W-1:0]  output_sel_d;
  logic               hazard_stall;
`ifdef DEC_ILLEGAL_TRAP_EN
  logic               illegal_d;
  logic               illegal_seen;
`endif

  modport master (
    output flush, in_valid, instruction, neg, zer, out_ready,
    input  in_ready, out_valid, opcode_d, rs_d, rt_d, rd_d, shamt_d, funct_d,
           constant_d, address_d, const_en_d, write_en_d, read_en_d, write_en2_d,
           j_sel_d, pc_sel_d, hilo_en_d, output_sel_d, hazard_stall
`ifdef DEC_ILLEGAL_TRAP_EN
    , input illegal_d, illegal_seen
`endif
  );

  modport slave (
    input  flush, in_valid, instruction, neg, zer, out_ready,
    output in_ready, out_valid, opcode_d, rs_d, rt_d, rd_d, shamt_d, funct_d,
           constant_d, address_d, const_en_d, write_en_d, read_en_d, write_en2_d,
           j_sel_d, pc_sel_d, hilo_en_d, output_sel_d, hazard_stall
`ifdef DEC_ILLEGAL_TRAP_EN
    , output illegal_d, illegal_seen
`endif
  );
endinterface

// File: rtl/dec_stage_pipe.sv
// Pipelined instruction decoder: field split + control decode into a decode->execute
// register with valid/ready, load-use interlock and flush. Option: DEC_ILLEGAL_TRAP_EN.
module dec_stage_pipe #(
  parameter int REG_W  = 3,
  parameter int OSEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  dec_stage_pipe_if.slave  bus
);
  localparam int INSTR_W = 4 + 4*REG_W;
  localparam logic [OSEL_W-1:0] OSEL_NONE = '1;

  typedef struct packed {
    logic [3:0]         opcode;
    logic [REG_W-1:0]   rs, rt, rd, shamt, funct;
    logic [2*REG_W-1:0] constant;
    logic [3*REG_W-1:0] address;
    logic               const_en, write_en, read_en, write_en2;
    logic               j_sel, pc_sel, hilo_en;
    logic [OSEL_W-1:0]  output_sel;
`ifdef DEC_ILLEGAL_TRAP_EN
    logic               illegal;
`endif
  } bundle_t;

  logic [INSTR_W-1:0] instr;
  logic [REG_W-1:0]   fn;
  logic               cond_ok, hazard, rdy, accept, vld_q;
  bundle_t            dec, q;

  assign instr = bus.instruction;
  assign fn    = instr[4+3*REG_W +: REG_W];

  // Conditional ALU ops (funct 1/2) only commit when their flag is set.
  assign cond_ok = (fn == REG_W'(1)) ? bus.neg :
                   (fn == REG_W'(2)) ? bus.zer : 1'b1;

  always_comb begin
    dec            = '0;
    dec.output_sel = OSEL_NONE;
    dec.opcode     = instr[3:0];
    dec.rd         = instr[4 +: REG_W];
    dec.rs         = instr[4+REG_W +: REG_W];
    // Stores name their data register in the rd slot.
    dec.rt         = (instr[3:0] == 4'd8) ? instr[4 +: REG_W] : instr[4+2*REG_W +: REG_W];
    dec.funct      = fn;
    dec.shamt      = fn;
    dec.constant   = instr[4+2*REG_W +: 2*REG_W];
    dec.address    = instr[4 +: 3*REG_W];
    case (instr[3:0])
      4'd0: if (cond_ok) begin
        dec.output_sel = OSEL_W'(1);
        dec.write_en2  = 1'b1;
        dec.hilo_en    = 1'b1;
      end
      4'd1, 4'd2, 4'd3, 4'd4: begin
        dec.output_sel = OSEL_W'(1);
        dec.write_en2  = 1'b1;
        dec.hilo_en    = 1'b1;
      end
      4'd5: begin
        dec.output_sel = OSEL_W'(1);
        dec.const_en   = 1'b1;
        dec.write_en2  = 1'b1;
      end
      4'd6: begin
        dec.output_sel = OSEL_W'(4);
        dec.write_en2  = 1'b1;
      end
      4'd7: begin
        dec.output_sel = OSEL_W'(0);
        dec.const_en   = 1'b1;
        dec.read_en    = 1'b1;
        dec.write_en2  = 1'b1;
      end
      4'd8: begin
        dec.const_en   = 1'b1;
        dec.write_en   = 1'b1;
      end
      4'd9: begin
        dec.j_sel      = (fn == '0);
        dec.pc_sel     = (fn != '0);
      end
      4'd10: dec.hilo_en = 1'b1;
      4'd11: begin
        dec.output_sel = OSEL_W'(3);
        dec.write_en2  = 1'b1;
      end
      4'd12: begin
        dec.output_sel = OSEL_W'(2);
        dec.write_en2  = 1'b1;
      end
      default: begin
`ifdef DEC_ILLEGAL_TRAP_EN
        dec.illegal = 1'b1;
`endif
      end
    endcase
  end

  // Load in the output register whose destination feeds this instruction.
  assign hazard = vld_q && q.read_en && ((q.rd == dec.rs) || (q.rd == dec.rt));
  assign rdy    = (!vld_q || bus.out_ready) && !hazard && !bus.flush;
  assign accept = bus.in_valid && rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q        <= 1'b0;
      q            <= '0;
      q.output_sel <= OSEL_NONE;
    end else if (bus.flush) begin
      vld_q <= 1'b0;
    end else if (accept) begin
      vld_q <= 1'b1;
      q     <= dec;
    end else if (bus.out_ready) begin
      vld_q <= 1'b0;
    end
  end

`ifdef DEC_ILLEGAL_TRAP_EN
  logic seen_q;
  always_ff @(posedge clk) begin
    if (rst)                        seen_q <= 1'b0;
    else if (accept && dec.illegal) seen_q <= 1'b1;
  end
  assign bus.illegal_d    = q.illegal;
  assign bus.illegal_seen = seen_q;
`endif

  assign bus.in_ready     = rdy;
  assign bus.hazard_stall = hazard && bus.in_valid;
  assign bus.out_valid    = vld_q;
  assign bus.opcode_d     = q.opcode;
  assign bus.rs_d         = q.rs;
  assign bus.rt_d         = q.rt;
  assign bus.rd_d         = q.rd;
  assign bus.shamt_d      = q.shamt;
  assign bus.funct_d      = q.funct;
  assign bus.constant_d   = q.constant;
  assign bus.address_d    = q.address;
  assign bus.const_en_d   = q.const_en;
  assign bus.write_en_d   = q.write_en;
  assign bus.read_en_d    = q.read_en;
  assign bus.write_en2_d  = q.write_en2;
  assign bus.j_sel_d      = q.j_sel;
  assign bus.pc_sel_d     = q.pc_sel;
  assign bus.hilo_en_d    = q.hilo_en;
  assign bus.output_sel_d = q.output_sel;
endmodule
